// File: rtl/imem_fetch.sv
// imem_fetch: synchronous instruction memory with fetch handshake, program-load port and optional post-reset NOP scrub (IMEM_ZERO_FILL_EN).
// Latency: one cycle from accepted fetch to instr_valid; back-to-back fetches give one instruction per cycle.
// Backpressure: stall with instr_valid freezes the result and drops fetch_ready; a load or an active fill also drops fetch_ready.
module imem_fetch #(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        instr_fault,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] fetch_idx;
  logic [AW-1:0] ld_idx;
  logic          fetch_oor;
  logic          fetch_mis;
  logic          ld_oor;
  logic          running;
  logic          accept;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          unused_ld_lsb;

  // Word index is the byte address shifted by two; any bit above the index
  // field means the address lies beyond the array.
  assign fetch_idx     = fetch_addr[AW+1:2];
  assign ld_idx        = ld_addr[AW+1:2];
  assign fetch_oor     = |fetch_addr[31:AW+2];
  assign ld_oor        = |ld_addr[31:AW+2];
  assign fetch_mis     = |fetch_addr[1:0];
  assign unused_ld_lsb = ^ld_addr[1:0];

`ifdef IMEM_ZERO_FILL_EN
  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t        state;
  logic [AW-1:0] fill_cnt;
  logic          busy_q;

  // Fill sequencer: sweep every word once after reset, then hand over to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FILL;
      fill_cnt <= '0;
      busy_q   <= 1'b1;
    end else if (state == S_FILL) begin
      if (fill_cnt == AW'(DEPTH - 1)) begin
        state  <= S_RUN;
        busy_q <= 1'b0;
      end else begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  assign running = (state == S_RUN);
  assign busy    = busy_q;

  // Single write port: the scrub owns it during FILL, program load afterwards.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ld_idx;
    mem_wdata = ld_data;
    if (!running) begin
      mem_we    = !rst;
      mem_waddr = fill_cnt;
      mem_wdata = NOP;
    end else begin
      mem_we    = ld_we && !ld_oor && !rst;
    end
  end
`else
  assign running   = 1'b1;
  assign busy      = 1'b0;
  assign mem_we    = ld_we && !ld_oor && !rst;
  assign mem_waddr = ld_idx;
  assign mem_wdata = ld_data;
`endif

  // Loads win over fetches; a held result blocks new fetches until stall drops.
  assign fetch_ready = running && !rst && !ld_we && !(instr_valid && stall);
  assign accept      = fetch_req && fetch_ready;

  // Memory array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read result with stall hold and fault substitution.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid <= 1'b0;
      instr       <= NOP;
      instr_fault <= 1'b0;
    end else if (accept) begin
      instr_valid <= 1'b1;
      if (fetch_mis || fetch_oor) begin
        instr       <= NOP;
        instr_fault <= 1'b1;
      end else begin
        instr       <= mem[fetch_idx];
        instr_fault <= 1'b0;
      end
    end else if (!(stall && instr_valid)) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Synchronous, parametrised instruction memory for the pipelined RISC-V core, sitting between the IF-stage PC and the IF/ID register. It replaces the combinational word-indexed ROM with a registered one-cycle read, a valid/ready fetch handshake with stall hold, and a runtime program-load write port. It also raises a fault on misaligned or out-of-range fetches and can optionally scrub memory to NOPs after reset.

## Interface
Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, 2..65536
- NOP, 32'h00000013, word returned on fault and used for fill (addi x0,x0,0)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- fetch_req  in  1  IF stage requests an instruction
- fetch_addr  in  32  byte address of the instruction
- fetch_ready  out  1  fetch accepted this cycle when fetch_req && fetch_ready
- stall  in  1  downstream cannot take instr this cycle
- instr_valid  out  1  instr/instr_fault hold a fetch result
- instr  out  32  fetched word
- instr_fault  out  1  result came from a misaligned or out-of-range address
- ld_we  in  1  program-load write strobe
- ld_addr  in  32  byte address of the load word; bits [1:0] ignored
- ld_data  in  32  word to write
- busy  out  1  fill sweep in progress

## Operation
- Word index = fetch_addr >> 2, i.e. bits [$clog2(DEPTH)+1:2].
- States: FILL (only with IMEM_ZERO_FILL_EN), RUN. Reset enters FILL if enabled, else RUN.
- FILL: counter 0..DEPTH-1 writes NOP to mem[counter], one word per cycle. It goes to RUN the cycle after writing DEPTH-1. busy=1 and fetch_ready=0 throughout; ld_we is ignored.
- RUN: fetch_ready = !ld_we && !(instr_valid && stall).
- Load: in RUN, ld_we=1 writes ld_data to mem[ld_addr>>2] at the clock edge. Writes with ld_addr>>2 >= DEPTH are dropped silently. A load has priority over a fetch: fetch_ready is 0 in that cycle.
- Accepted fetch: the next edge registers instr_valid=1 and one of:
  - fetch_addr[1:0]!=0 → instr_fault=1, instr=NOP
  - fetch_addr>>2 >= DEPTH → instr_fault=1, instr=NOP
  - otherwise → instr_fault=0, instr=mem[index]
- No accept:
  - stall=1 && instr_valid=1 → hold instr, instr_fault and instr_valid unchanged.
  - otherwise → instr_valid←0; instr/instr_fault keep their last values (don't-care).
- Memory contents are not cleared by reset unless IMEM_ZERO_FILL_EN is defined.

## Timing
- Reset values: instr_valid=0, instr=NOP, instr_fault=0, busy=1 with fill (else 0), fill counter=0.
- fetch_ready is combinational from state, ld_we, stall and instr_valid. It is 0 while rst is asserted.
- Read latency is 1 cycle: address accepted at edge N produces data valid after edge N.
- Back-to-back fetches every cycle are supported with stall=0, giving one instruction per cycle.
- A load at edge N followed by a fetch of the same address accepted at edge N+1 returns the new data.
- Stall asserted with instr_valid=1: output frozen and fetch_ready=0 until stall drops. The next fetch can be accepted in the same cycle stall drops.
- rst asserted mid-FILL or mid-fetch: outputs return to reset values immediately. FILL restarts from word 0 after rst deasserts.
- Fill duration is exactly DEPTH cycles after rst deasserts; busy falls after the cycle that writes word DEPTH-1.

## Configuration
- IMEM_ZERO_FILL_EN defined: FILL state, counter and busy logic are present. Every reset scrubs all DEPTH words to NOP before RUN.
- Undefined: no FILL state, busy tied 0, RUN is entered straight from reset, and memory keeps prior contents across reset.

## Test plan
- Load word 0x00200313 at byte address 0x8, then fetch 0x8 → next cycle instr_valid=1, instr=0x00200313, instr_fault=0.
- Fetch 0x6 (misaligned), then fetch 0x1000 with DEPTH=1024 → both return instr=0x00000013, instr_fault=1.
- Stream fetches 0x0, 0x4, 0x8 with stall=1 on the second result for 3 cycles → second word held 3 cycles, fetch_ready=0 while stalled, and the third word follows the cycle after stall drops.
- Assert ld_we together with fetch_req → fetch_ready=0, the write lands, and the fetch is accepted the next cycle.
- With IMEM_ZERO_FILL_EN and DEPTH=16: preload word 5 with 0xDEADBEEF, pulse rst → busy high for 16 cycles, then fetch 0x14 returns 0x00000013.
- Assert rst mid-fill at count 7 → busy stays 1, instr_valid=0, and the full 16-cycle fill repeats after rst deasserts.
